// File: rtl/fmb_pkg.sv
// Shared types for the fault map builder: word classes,
// error codes and scan FSM states.
package fmb_pkg;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_SINGLE = 2'b01;
    localparam logic [1:0] ERR_MULTI  = 2'b10;
    localparam logic [1:0] ERR_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        OK,
        FLIP,
        PATCH
    } word_class_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

endpackage

// File: rtl/word_classifier.sv
// Combinational worst-of-two classification of a word's
// zeros-sweep and ones-sweep error codes.
module word_classifier
    import fmb_pkg::*;
(
    input  logic [1:0]  err0,
    input  logic [1:0]  err1,
    output word_class_t cls
);

    logic multi;
    logic single;

    assign multi = (err0 == ERR_MULTI) || (err0 == ERR_RSVD) ||
                   (err1 == ERR_MULTI) || (err1 == ERR_RSVD);
    assign single = (err0 == ERR_SINGLE) || (err1 == ERR_SINGLE);

    // Multi-bit (or reserved) dominates single-bit.
    always_comb begin
        cls = OK;
        priority case (1'b1)
            multi:   cls = PATCH;
            single:  cls = FLIP;
            default: cls = OK;
        endcase
    end

endmodule

// File: rtl/fault_map_builder.sv
// Scans both error maps once per start, counts FLIP/PATCH words
// and records PATCH addresses in a small lookup table.
module fault_map_builder
    import fmb_pkg::*;
#(
    parameter int N_WORDS = 64,
    parameter int ADDR_W  = $clog2(N_WORDS),
    parameter int N_PATCH = 8,
    parameter int CNT_W   = $clog2(N_WORDS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic [ADDR_W-1:0]          err_addr,
    input  logic [1:0]                 err0_data,
    input  logic [1:0]                 err1_data,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           n_flip,
    output logic [CNT_W-1:0]           n_patch,
    output logic                       overflow,
    input  logic [ADDR_W-1:0]          q_addr,
    output logic                       q_hit,
    output logic [$clog2(N_PATCH)-1:0] q_slot
);

    localparam int SLOT_W = $clog2(N_PATCH);
    localparam int PTR_W  = $clog2(N_PATCH + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(N_WORDS);
    localparam logic [PTR_W-1:0]  PTR_FULL  = PTR_W'(N_PATCH);

    state_t            state;
    word_class_t       cls;
    logic [PTR_W-1:0]  wr_ptr;
    logic [N_PATCH-1:0] valid;
    logic [ADDR_W-1:0] tbl [N_PATCH];

    word_classifier u_cls (
        .err0 (err0_data),
        .err1 (err1_data),
        .cls  (cls)
    );

    // Scan FSM: one address classified per cycle, table filled in order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            err_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            n_flip   <= '0;
            n_patch  <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            valid    <= '0;
            for (int i = 0; i < N_PATCH; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= SCAN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err_addr <= '0;
                        n_flip   <= '0;
                        n_patch  <= '0;
                        overflow <= 1'b0;
                        wr_ptr   <= '0;
                        valid    <= '0;
                    end
                end
                SCAN: begin
                    unique case (cls)
                        FLIP: begin
                            if (n_flip != CNT_MAX)
                                n_flip <= n_flip + CNT_W'(1);
                        end
                        PATCH: begin
                            if (n_patch != CNT_MAX)
                                n_patch <= n_patch + CNT_W'(1);
                            if (wr_ptr == PTR_FULL) begin
                                overflow <= 1'b1;
                            end else begin
                                tbl[wr_ptr[SLOT_W-1:0]]   <= err_addr;
                                valid[wr_ptr[SLOT_W-1:0]] <= 1'b1;
                                wr_ptr <= wr_ptr + PTR_W'(1);
                            end
                        end
                        default: ;
                    endcase
                    if (err_addr == LAST_ADDR) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        err_addr <= err_addr + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lookup: iterate high-to-low so the lowest matching slot wins.
    always_comb begin
        q_hit  = 1'b0;
        q_slot = '0;
        for (int i = N_PATCH - 1; i >= 0; i--) begin
            if (valid[i] && tbl[i] == q_addr) begin
                q_hit  = 1'b1;
                q_slot = SLOT_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_fault_map_builder.sv
// Scoreboard bench for fault_map_builder: expected scan results
// are queued at start and compared when done rises.
module tb_fault_map_builder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] err_addr;
    logic [1:0] err0_data;
    logic [1:0] err1_data;
    logic       busy;
    logic       done;
    logic [6:0] n_flip;
    logic [6:0] n_patch;
    logic       overflow;
    logic [5:0] q_addr;
    logic       q_hit;
    logic [2:0] q_slot;

    logic [1:0] err0_map [64];
    logic [1:0] err1_map [64];

    assign err0_data = err0_map[err_addr];
    assign err1_data = err1_map[err_addr];

    always #5 clk = ~clk;

    fault_map_builder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .err_addr  (err_addr),
        .err0_data (err0_data),
        .err1_data (err1_data),
        .busy      (busy),
        .done      (done),
        .n_flip    (n_flip),
        .n_patch   (n_patch),
        .overflow  (overflow),
        .q_addr    (q_addr),
        .q_hit     (q_hit),
        .q_slot    (q_slot)
    );

    typedef struct packed {
        logic [6:0]      flip;
        logic [6:0]      patch;
        logic            ovf;
        logic [3:0]      nent;
        logic [7:0][5:0] ent;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sev(input logic [1:0] c);
        if (c == 2'b00) return 0;
        if (c == 2'b01) return 1;
        return 2;
    endfunction

    function automatic exp_t model();
        exp_t e;
        int   w;
        e = '0;
        for (int a = 0; a < 64; a++) begin
            w = sev(err0_map[a]);
            if (sev(err1_map[a]) > w) w = sev(err1_map[a]);
            if (w == 1) e.flip = e.flip + 7'd1;
            if (w == 2) begin
                e.patch = e.patch + 7'd1;
                if (e.nent < 4'd8) begin
                    e.ent[e.nent[2:0]] = 6'(a);
                    e.nent = e.nent + 4'd1;
                end else begin
                    e.ovf = 1'b1;
                end
            end
        end
        return e;
    endfunction

    // Expected hit for address a when addresses below limit are scanned.
    task automatic exp_hit(input exp_t e, input int a, input int limit,
                           output int hit, output int slot);
        hit  = 0;
        slot = 0;
        for (int i = 7; i >= 0; i--) begin
            if (i < int'(e.nent) && int'(e.ent[i]) == a && a < limit) begin
                hit  = 1;
                slot = i;
            end
        end
    endtask

    task automatic clear_maps();
        for (int a = 0; a < 64; a++) begin
            err0_map[a] = 2'b00;
            err1_map[a] = 2'b00;
        end
    endtask

    task automatic run_scan(input int pulse_at, input int abort_at,
                            input int probe);
        exp_t e;
        int   cyc;
        int   hit;
        int   slot;
        bit   fin;
        @(posedge clk);
        #1;
        start  = 1'b1;
        q_addr = (probe >= 0) ? 6'(probe) : 6'd0;
        sb.push_back(model());
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_n_flip", n_flip, 0);
        check("start_n_patch", n_patch, 0);
        check("start_overflow", overflow, 0);
        check("start_err_addr", err_addr, 0);
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == pulse_at);
            if (cyc == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_n_flip", n_flip, 0);
                check("abort_n_patch", n_patch, 0);
                check("abort_overflow", overflow, 0);
                check("abort_err_addr", err_addr, 0);
                check("abort_q_hit", q_hit, 0);
                void'(sb.pop_front());
                @(posedge clk);
                #1;
                reset = 1'b0;
                return;
            end
            if (done) begin
                fin = 1'b1;
            end else if (probe >= 0) begin
                exp_hit(sb[0], probe, cyc, hit, slot);
                check("scan_q_hit", q_hit, hit);
            end
        end
        if (!fin) begin
            check("done_timeout", 0, 1);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check("scan_cycles", cyc, 64);
        check("n_flip", n_flip, int'(e.flip));
        check("n_patch", n_patch, int'(e.patch));
        check("overflow", overflow, int'(e.ovf));
        check("done_busy", busy, 0);
        check("done_err_addr", err_addr, 63);
        for (int a = 0; a < 64; a++) begin
            q_addr = 6'(a);
            #1;
            exp_hit(e, a, 64, hit, slot);
            check("q_hit", q_hit, hit);
            if (hit != 0) check("q_slot", q_slot, slot);
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        q_addr = 6'd0;
        clear_maps();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_n_flip", n_flip, 0);
        check("rst_n_patch", n_patch, 0);
        check("rst_overflow", overflow, 0);
        check("rst_q_hit", q_hit, 0);
        check("rst_q_slot", q_slot, 0);
        reset = 1'b0;

        // All maps clean.
        run_scan(-1, -1, -1);

        // One FLIP at 5, one PATCH at 9.
        clear_maps();
        err1_map[5] = 2'b01;
        err0_map[9] = 2'b10;
        err1_map[9] = 2'b01;
        run_scan(-1, -1, 9);

        // Reset mid-scan, then a full rescan.
        run_scan(-1, 20, 9);
        @(posedge clk);
        #1;
        check("idle_err_addr", err_addr, 0);
        check("idle_busy", busy, 0);
        run_scan(-1, -1, 9);

        // Ten PATCH words overflow the table; start during scan ignored.
        clear_maps();
        for (int a = 0; a < 10; a++) err0_map[a] = 2'b10;
        run_scan(30, -1, 3);

        // Reserved code at the last address; start issued from DONE.
        clear_maps();
        err1_map[63] = 2'b11;
        run_scan(-1, -1, 63);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fault_map_builder.md
FAULT_MAP_BUILDER -- requirements
Module: fault_map_builder

Interface
REQ-001 Parameter N_WORDS, default 64, number of words in the memory under test.
REQ-002 Parameter ADDR_W, default $clog2(N_WORDS), address width.
REQ-003 Parameter N_PATCH, default 8, number of patch-table entries.
REQ-004 Parameter CNT_W, default $clog2(N_WORDS+1), counter width.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse from the sweep controller's all_done rise; begins a scan.
REQ-008 err_addr  out  ADDR_W  read address into both error maps.
REQ-009 err0_data  in  2  error_0[err_addr] (zeros sweep); combinational, valid in the same cycle.
REQ-010 err1_data  in  2  error_1[err_addr] (ones sweep); combinational, valid in the same cycle.
REQ-011 busy  out  1  scan in progress.
REQ-012 done  out  1  scan complete; results stable.
REQ-013 n_flip  out  CNT_W  number of words classified FLIP.
REQ-014 n_patch  out  CNT_W  number of words classified PATCH, including words not stored.
REQ-015 overflow  out  1  more PATCH words than N_PATCH.
REQ-016 q_addr  in  ADDR_W  lookup address.
REQ-017 q_hit  out  1  q_addr is held in a valid patch entry.
REQ-018 q_slot  out  $clog2(N_PATCH)  index of the matching entry.

Function
REQ-019 Error code: 00 none, 01 single-bit, 10 multi-bit, 11 reserved, which shall be treated as multi-bit.
REQ-020 Word class is the worse of the two codes: both 00 -> OK; worst 01 -> FLIP; any 10/11 -> PATCH.
REQ-021 FSM states are IDLE, SCAN and DONE; IDLE->SCAN and DONE->SCAN on start; SCAN->DONE after address N_WORDS-1 is classified.
REQ-022 On entering SCAN, clear counters, overflow and all table valid bits; set err_addr=0.
REQ-023 In SCAN, classify one address per cycle and increment err_addr; a scan takes exactly N_WORDS cycles.
REQ-024 busy=1 exactly in SCAN; done=1 exactly in DONE; done rises the cycle after the last address is classified.
REQ-025 Ignore start while in SCAN.
REQ-026 Store each PATCH address in the next free entry, in ascending address order, and set its valid bit.
REQ-027 When a PATCH word arrives with all N_PATCH entries valid: set overflow sticky, do not store the word, still increment n_patch.
REQ-028 Counters saturate at N_WORDS and cannot wrap.
REQ-029 q_hit/q_slot are combinational on q_addr; on multiple matches q_slot is the lowest index; when q_hit=0, q_slot=0.
REQ-030 Lookups during SCAN reflect only the entries written so far.
REQ-031 err_addr holds at N_WORDS-1 in DONE and is 0 in IDLE.

Reset
REQ-032 Reset forces: state IDLE, err_addr 0, busy 0, done 0, counters 0, overflow 0, all valid bits 0.
REQ-033 Reset mid-SCAN aborts the scan; a new start rescans from address 0.

Structure
REQ-034 Shared package fmb_pkg holds the word-class enum (OK, FLIP, PATCH), the 2-bit error-code constants and the FSM state enum.
REQ-035 Classification is the natural sub-module, word_classifier: purely combinational, 2+2 bits in, class out.
REQ-036 The patch table (N_PATCH x ADDR_W plus valid bits) stays inside fault_map_builder.

Verification
REQ-037 All maps 00, start -> done after 64 cycles, n_flip=0, n_patch=0, overflow=0, q_hit=0 for every address.
REQ-038 error_1[5]=01, error_0[9]=10, error_1[9]=01 -> n_flip=1, n_patch=1, entry0=9, q_addr=9 gives q_hit=1/q_slot=0, q_addr=5 gives q_hit=0.
REQ-039 PATCH at addresses 0..9 (10 words, N_PATCH=8) -> n_patch=10, overflow=1, entries hold 0..7, q_addr=8 gives q_hit=0.
REQ-040 Code 11 at address 63 only -> classified PATCH, n_patch=1, entry0=63.
REQ-041 Reset asserted at cycle 20 of a scan -> all outputs at reset values; a new start gives a full 64-cycle scan with correct counts.
REQ-042 start pulsed at scan cycle 30 -> ignored, done at cycle 64; start in DONE -> results cleared and a rescan performed.
